// File: rtl/calc_pkg.sv
// Shared types for the calculator operation sequencer: op codes, FSM states, default operand width.
package calc_pkg;

  localparam int OPW_DEFAULT = 4;

  // Encoding matches btn[1:0] on the board.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Request/result bundle between the switch/button front end and the operation sequencer.
interface calc_op_sequencer_if #(parameter int OPW = calc_pkg::OPW_DEFAULT);
  import calc_pkg::*;

  logic             start;
  op_e              op;
  logic [OPW-1:0]   a;
  logic [OPW-1:0]   b;
  logic             busy;
  logic             done;
  logic [2*OPW-1:0] result;
  logic             err;

  modport master (output start, op, a, b, input busy, done, result, err);
  modport slave  (input start, op, a, b, output busy, done, result, err);

endinterface

// File: rtl/calc_iter_unit.sv
// Iterative shift-add multiplier and restoring divider, one step per cycle when step is high.
// Outputs show the value after the current step, so they are final during the last step cycle.
module calc_iter_unit #(
  parameter int OPW = calc_pkg::OPW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [2*OPW-1:0] product,
  output logic [OPW-1:0]   quotient,
  output logic [OPW-1:0]   remainder
);

  logic [2*OPW-1:0] acc, mcand, acc_nxt;
  logic [OPW-1:0]   mplier, quot, rem, divisor;
  logic [OPW-1:0]   quot_nxt, rem_nxt;
  logic [OPW:0]     trial, diff;
  logic             ge;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Partial remainder stays below the divisor, so the sign of diff decides restore vs keep.
  assign trial    = {rem, quot[OPW-1]};
  assign diff     = trial - {1'b0, divisor};
  assign ge       = ~diff[OPW];
  assign quot_nxt = {quot[OPW-2:0], ge};
  assign rem_nxt  = ge ? diff[OPW-1:0] : trial[OPW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
    end else if (load) begin
      acc     <= '0;
      mcand   <= {{OPW{1'b0}}, b};
      mplier  <= a;
      rem     <= '0;
      quot    <= a;
      divisor <= b;
    end else if (step) begin
      acc     <= acc_nxt;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      rem     <= rem_nxt;
      quot    <= quot_nxt;
    end
  end

  assign product   = acc_nxt;
  assign quotient  = quot_nxt;
  assign remainder = rem_nxt;

endmodule

// File: rtl/calc_op_sequencer.sv
// Sequences one ADD/SUB/MUL/DIV request over a shared datapath; ADD/SUB/DIV-by-0 take 1 compute cycle, MUL/DIV take OPW.
// start is only sampled in IDLE; CALC_SEQ_REMAINDER_EN packs the DIV remainder into result[2*OPW-1:OPW].
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  calc_op_sequencer_if.slave bus
);

  localparam int RW = 2 * OPW;
  localparam int CW = (OPW > 1) ? $clog2(OPW) : 1;

  state_e         state, state_nxt;
  logic [CW-1:0]  cnt;
  op_e            op_q;
  logic [OPW-1:0] a_q, b_q;
  logic [RW-1:0]  result_q, calc_res, div_res, dbz_res;
  logic           err_q, calc_err;
  logic           load, step, last_step, busy, done;
  logic [RW-1:0]  iter_prod;
  logic [OPW-1:0] iter_quot, iter_rem;

  calc_iter_unit #(.OPW(OPW)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .a         (bus.a),
    .b         (bus.b),
    .product   (iter_prod),
    .quotient  (iter_quot),
    .remainder (iter_rem)
  );

  assign last_step = (cnt == CW'(OPW - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          load = 1'b1;
          if ((bus.op == OP_MUL) || ((bus.op == OP_DIV) && (bus.b != '0)))
            state_nxt = ST_ITER;
          else
            state_nxt = ST_CALC;
        end
      end
      ST_CALC: state_nxt = ST_DONE;
      ST_ITER: begin
        step = 1'b1;
        if (last_step) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef CALC_SEQ_REMAINDER_EN
  assign div_res = {iter_rem, iter_quot};
  assign dbz_res = {a_q, {OPW{1'b1}}};
`else
  logic [OPW-1:0] unused_rem;
  assign unused_rem = iter_rem;
  assign div_res    = {{OPW{1'b0}}, iter_quot};
  assign dbz_res    = {{OPW{1'b0}}, {OPW{1'b1}}};
`endif

  // MUL never reaches CALC, so the default arm only serves divide-by-zero.
  always_comb begin
    calc_res = '0;
    calc_err = 1'b0;
    case (op_q)
      OP_ADD:  calc_res = {{OPW{1'b0}}, a_q} + {{OPW{1'b0}}, b_q};
      OP_SUB:  calc_res = {{OPW{1'b0}}, a_q} - {{OPW{1'b0}}, b_q};
      default: begin
        calc_res = dbz_res;
        calc_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
        cnt  <= '0;
      end
      if (step) cnt <= cnt + CW'(1);
      if (state == ST_CALC) begin
        result_q <= calc_res;
        err_q    <= calc_err;
      end else if (step && last_step) begin
        result_q <= (op_q == OP_MUL) ? iter_prod : div_res;
        err_q    <= 1'b0;
      end
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with a cycle-count reference model checked every cycle.
module tb_calc_op_sequencer;
  import calc_pkg::*;

`ifdef CALC_SEQ_REMAINDER_EN
  localparam bit REM = 1'b1;
  localparam logic [7:0] EXP_DIV_D4 = 8'h13;
  localparam logic [7:0] EXP_DIV_70 = 8'h7F;
`else
  localparam bit REM = 1'b0;
  localparam logic [7:0] EXP_DIV_D4 = 8'h03;
  localparam logic [7:0] EXP_DIV_70 = 8'h0F;
`endif

  typedef struct packed {
    logic [7:0] r;
    logic       e;
    logic [3:0] lat;
  } mres_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  calc_op_sequencer_if #(.OPW(4)) bus ();

  calc_op_sequencer #(.OPW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Plain-arithmetic reference: result, error flag and compute latency of one request.
  function automatic mres_t model_op(input logic [1:0] op_v, input int av, input int bv);
    mres_t m;
    m.e = 1'b0;
    m.lat = 4'd4;
    m.r = 8'h00;
    case (op_v)
      2'b00: begin m.r = 8'(av + bv); m.lat = 4'd1; end
      2'b01: begin m.r = 8'(av - bv); m.lat = 4'd1; end
      2'b11: m.r = 8'(av * bv);
      default: begin
        if (bv == 0) begin
          m.e = 1'b1;
          m.lat = 4'd1;
          m.r = REM ? 8'(av * 16 + 15) : 8'h0F;
        end else begin
          m.r = REM ? 8'((av % bv) * 16 + av / bv) : 8'(av / bv);
        end
      end
    endcase
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_left counts busy cycles still to come (0 = idle, 1 = the done cycle).
  int         m_left = 0;
  logic [7:0] m_res = 8'h00, m_pres = 8'h00;
  logic       m_err = 1'b0, m_perr = 1'b0;
  mres_t      nxt;

  assign nxt = model_op(bus.op, int'(bus.a), int'(bus.b));

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_res  <= 8'h00;
      m_err  <= 1'b0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        m_pres <= nxt.r;
        m_perr <= nxt.e;
        m_left <= int'(nxt.lat) + 1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_res <= m_pres;
        m_err <= m_perr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy",   32'(bus.busy),   32'(m_left != 0));
      check("cyc_done",   32'(bus.done),   32'(m_left == 1));
      check("cyc_result", 32'(bus.result), 32'(m_res));
      check("cyc_err",    32'(bus.err),    32'(m_err));
    end
  end

  task automatic run_op(input string name, input op_e op_v, input logic [3:0] a_v,
                        input logic [3:0] b_v, input bit hold, input logic [7:0] exp_r,
                        input logic exp_e, input int exp_lat);
    int lat;
    lat = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = op_v;
    bus.a = a_v;
    bus.b = b_v;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (!hold) begin
        bus.start = 1'b0;
      end else begin
        bus.a = ~bus.a;
        bus.b = bus.b ^ 4'h5;
      end
      if (bus.done) begin
        lat = i;
        check({name, "_result"}, 32'(bus.result), 32'(exp_r));
        check({name, "_err"}, 32'(bus.err), 32'(exp_e));
      end
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (hold) begin
      // start stays high through DONE; it must not launch a second operation there.
      @(negedge clk);
      bus.start = 1'b0;
      check({name, "_no_restart"}, 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mres_t t;
    bus.start = 1'b0;
    bus.op = OP_ADD;
    bus.a = 4'h0;
    bus.b = 4'h0;

    t = model_op(2'b11, 15, 15);
    check("model_mul_ff", 32'(t.r), 32'h0E1);
    t = model_op(2'b01, 3, 5);
    check("model_sub_35", 32'(t.r), 32'h0FE);
    t = model_op(2'b10, 13, 4);
    check("model_div_d4", 32'(t.r), 32'(EXP_DIV_D4));
    t = model_op(2'b10, 7, 0);
    check("model_div_70", 32'({t.r, t.e}), 32'({EXP_DIV_70, 1'b1}));

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    rst = 1'b0;

    run_op("add_ff",  OP_ADD, 4'hF, 4'hF, 1'b0, 8'h1E, 1'b0, 1);
    run_op("sub_35",  OP_SUB, 4'h3, 4'h5, 1'b0, 8'hFE, 1'b0, 1);
    run_op("mul_ff",  OP_MUL, 4'hF, 4'hF, 1'b0, 8'hE1, 1'b0, 4);
    run_op("div_d4",  OP_DIV, 4'hD, 4'h4, 1'b0, EXP_DIV_D4, 1'b0, 4);
    run_op("div_70",  OP_DIV, 4'h7, 4'h0, 1'b0, EXP_DIV_70, 1'b1, 1);
    run_op("add_00",  OP_ADD, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1);
    run_op("mul_f0",  OP_MUL, 4'hF, 4'h0, 1'b0, 8'h00, 1'b0, 4);
    run_op("div_f1",  OP_DIV, 4'hF, 4'h1, 1'b0, REM ? 8'h0F : 8'h0F, 1'b0, 4);
    run_op("div_3f",  OP_DIV, 4'h3, 4'hF, 1'b0, REM ? 8'h30 : 8'h00, 1'b0, 4);
    run_op("mul_96h", OP_MUL, 4'h9, 4'h6, 1'b1, 8'h36, 1'b0, 4);

    // Reset lands on edge N+2 of a MUL.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = OP_MUL;
    bus.a = 4'h5;
    bus.b = 4'h3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", 32'(bus.result), 32'h00);
    check("rst_err",    32'(bus.err),    32'd0);
    rst = 1'b0;
    run_op("add_12", OP_ADD, 4'h1, 4'h2, 1'b0, 8'h03, 1'b0, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
